// File: rtl/ugemm_pkg.sv
// Shared types and constants for the rate-coded unary GEMM lane sequencer.
package ugemm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Maximal-length Fibonacci tap masks; bit i set means register bit i feeds the XOR.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] mask;
        case (width)
            8:       mask = 32'h0000_00B8;
            16:      mask = 32'h0000_D008;
            24:      mask = 32'h00E1_0000;
            32:      mask = 32'h8020_0003;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ugemm_lfsr.sv
// Fibonacci LFSR random-number source for the unary multiplier; reseedable, stallable.
module ugemm_lfsr
    import ugemm_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_reseed,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_rand
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    // An all-zero seed or missing tap table would lock the sequence at zero.
    generate
        if (SEED == '0 || TAPS == '0) begin : g_bad_cfg
            $fatal(1, "ugemm_lfsr: SEED must be nonzero and WIDTH must have a tap mask");
        end
    endgenerate

    logic [WIDTH-1:0] r_lfsr;
    logic             w_fb;

    assign w_fb   = ^(r_lfsr & TAPS);
    assign o_rand = r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_reseed) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[WIDTH-2:0], w_fb};
        end
    end

endmodule

// File: rtl/ugemm_rate_mac_ctrl.sv
// Job sequencer for one rate-coded unary multiply lane: streams weight/random buses,
// counts returned product bits and hands back the bipolar result.
module ugemm_rate_mac_ctrl
    import ugemm_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter int unsigned      CYC_W = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic [WIDTH-1:0]        i_cfg_w,
    input  logic [CYC_W-1:0]        i_cfg_len,
    input  logic                    i_stall,
    output logic                    o_run,
    output logic [WIDTH-1:0]        o_data_w,
    output logic [WIDTH-1:0]        o_randW,
    output logic [WIDTH-1:0]        o_randW_inv,
    input  logic                    i_bit_prod,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic signed [CYC_W+1:0] o_res,
    output logic                    o_busy
);

    state_e                  r_state;
    logic [WIDTH-1:0]        r_w;
    logic [CYC_W-1:0]        r_len;
    logic [CYC_W-1:0]        r_cnt;
    logic [CYC_W:0]          r_ones;
    logic                    r_iss_d;
    logic signed [CYC_W+1:0] r_res;

    logic                    w_issue;
    logic                    w_accept;
    logic [CYC_W:0]          w_ones_nxt;
    logic [CYC_W+1:0]        w_len_p1;
    logic [CYC_W+1:0]        w_res;
    logic [WIDTH-1:0]        w_rand;

    assign w_issue    = (r_state == RUN) && !i_stall;
    assign w_accept   = (r_state == IDLE) && i_cfg_valid;
    // The bit arriving this cycle belongs to last cycle's issue, if there was one.
    assign w_ones_nxt = r_ones + {{CYC_W{1'b0}}, r_iss_d & i_bit_prod};
    assign w_len_p1   = {2'b00, r_len} + (CYC_W+2)'(1);
    assign w_res      = {w_ones_nxt, 1'b0} - w_len_p1;

    ugemm_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_reseed (w_accept),
        .i_en     (w_issue),
        .o_rand   (w_rand)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_w     <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_ones  <= '0;
            r_iss_d <= 1'b0;
            r_res   <= '0;
        end else begin
            r_iss_d <= w_issue;
            if (r_iss_d) begin
                r_ones <= w_ones_nxt;
            end
            unique case (r_state)
                IDLE: begin
                    if (i_cfg_valid) begin
                        r_w     <= i_cfg_w;
                        r_len   <= i_cfg_len;
                        r_cnt   <= '0;
                        r_ones  <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!i_stall) begin
                        r_cnt <= r_cnt + CYC_W'(1);
                        if (r_cnt == r_len) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_res   <= w_res;
                    r_state <= DONE;
                end
                DONE: begin
                    if (i_res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cfg_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_res_valid = (r_state == DONE);
    assign o_run       = w_issue;
    assign o_data_w    = r_w;
    assign o_randW     = w_rand;
    assign o_randW_inv = ~w_rand;
    assign o_res       = r_res;

endmodule

// File: tb/tb_ugemm_rate_mac_ctrl.sv
// Directed self-checking bench for ugemm_rate_mac_ctrl (WIDTH=16, CYC_W=8, SEED=1).
module tb_ugemm_rate_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cfg_valid = 1'b0;
    logic        o_cfg_ready;
    logic [15:0] i_cfg_w = '0;
    logic [7:0]  i_cfg_len = '0;
    logic        i_stall = 1'b0;
    logic        o_run;
    logic [15:0] o_data_w;
    logic [15:0] o_randW;
    logic [15:0] o_randW_inv;
    logic        i_bit_prod = 1'b0;
    logic        o_res_valid;
    logic        i_res_ready = 1'b0;
    logic [9:0]  o_res;
    logic        o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ugemm_rate_mac_ctrl #(
        .WIDTH (16),
        .CYC_W (8),
        .SEED  (16'h0001)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_w     (i_cfg_w),
        .i_cfg_len   (i_cfg_len),
        .i_stall     (i_stall),
        .o_run       (o_run),
        .o_data_w    (o_data_w),
        .o_randW     (o_randW),
        .o_randW_inv (o_randW_inv),
        .i_bit_prod  (i_bit_prod),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res       (o_res),
        .o_busy      (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] r);
        return {r[14:0], r[15] ^ r[14] ^ r[12] ^ r[3]};
    endfunction

    // Product bit the lane returns for issue number k.
    function automatic logic bitfn(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return k[0];
            default: return (k % 3) == 0;
        endcase
    endfunction

    // Accepts a job and walks it to DONE; garbage 1s are driven when no bit is due.
    task automatic run_job(input logic [15:0] w, input int len, input int mode,
                           input int st_at, input int st_n, input logic [9:0] exp_res);
        int          issued = 0;
        int          gap = 0;
        int          prev_k = 0;
        int          cyc = 0;
        bit          prev_iss = 0;
        bit          stall;
        logic [15:0] exp_rand = 16'h0001;
        logic [15:0] exp_inv;
        chk("cfg_ready_idle", o_cfg_ready, 1);
        i_cfg_valid = 1'b1;
        i_cfg_w     = w;
        i_cfg_len   = 8'(len);
        step();
        i_cfg_valid = 1'b0;
        while (issued <= len && cyc < 600) begin
            stall = (issued == st_at) && (gap < st_n);
            if (stall) gap++;
            i_stall    = stall;
            i_bit_prod = prev_iss ? bitfn(mode, prev_k) : 1'b1;
            #2;
            exp_inv = ~exp_rand;
            chk("run", o_run, !stall);
            chk("randW", o_randW, exp_rand);
            chk("randW_inv", o_randW_inv, exp_inv);
            chk("data_w", o_data_w, w);
            chk("busy_ready_valid_run", {o_busy, o_cfg_ready, o_res_valid}, 3'b100);
            if (!stall) begin
                prev_k = issued;
                issued++;
                exp_rand = lfsr_next(exp_rand);
            end
            prev_iss = !stall;
            cyc++;
            step();
        end
        i_stall    = 1'b0;
        i_bit_prod = prev_iss ? bitfn(mode, prev_k) : 1'b1;
        #2;
        chk("drain_run", o_run, 0);
        chk("drain_valid", o_res_valid, 0);
        chk("drain_busy", o_busy, 1);
        step();
        i_stall    = 1'b1;
        i_bit_prod = 1'b1;
        #2;
        chk("done_valid", o_res_valid, 1);
        chk("done_res", o_res, exp_res);
        chk("done_run", o_run, 0);
    endtask

    task automatic take_res(input int hold, input logic [9:0] exp_res);
        for (int i = 0; i < hold; i++) begin
            i_res_ready = 1'b0;
            i_cfg_valid = 1'b1;
            #2;
            chk("hold_valid", o_res_valid, 1);
            chk("hold_res", o_res, exp_res);
            chk("hold_cfg_ready", o_cfg_ready, 0);
            step();
        end
        i_cfg_valid = 1'b0;
        i_res_ready = 1'b1;
        #2;
        chk("hs_valid", o_res_valid, 1);
        chk("hs_res", o_res, exp_res);
        step();
        i_res_ready = 1'b0;
        i_stall     = 1'b0;
        #2;
        chk("post_cfg_ready", o_cfg_ready, 1);
        chk("post_valid", o_res_valid, 0);
        chk("post_busy", o_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("rst_cfg_ready", o_cfg_ready, 1);
        chk("rst_randW", o_randW, 32'h0001);
        chk("rst_randW_inv", o_randW_inv, 32'hFFFE);
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_res", o_res, 0);
        chk("rst_data_w", o_data_w, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_run", o_run, 0);
        rst_n = 1'b1;
        step();

        // All-ones stream, then all-zeros, then full-length alternating stream.
        run_job(16'hA5A5, 3, 0, -1, 0, 10'(4));
        take_res(0, 10'(4));
        run_job(16'h1234, 3, 1, -1, 0, 10'(-4));
        take_res(0, 10'(-4));
        run_job(16'hFFFF, 255, 2, -1, 0, 10'(0));
        take_res(0, 10'(0));

        // Stall gap of 5 cycles before the 5th issue, then the same job unstalled.
        run_job(16'h00F0, 9, 3, 4, 5, 10'(-2));
        take_res(0, 10'(-2));
        run_job(16'h00F0, 9, 3, -1, 0, 10'(-2));
        take_res(0, 10'(-2));

        // Result held 10 cycles while a new job request is presented.
        run_job(16'h0F0F, 2, 0, -1, 0, 10'(3));
        take_res(10, 10'(3));

        // Reset in the middle of a stream.
        i_cfg_valid = 1'b1;
        i_cfg_w     = 16'hBEEF;
        i_cfg_len   = 8'd5;
        step();
        i_cfg_valid = 1'b0;
        i_stall     = 1'b0;
        step();
        step();
        #2;
        chk("mid_randW", o_randW, 32'h0004);
        chk("mid_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_cfg_ready", o_cfg_ready, 1);
        chk("mrst_randW", o_randW, 32'h0001);
        chk("mrst_valid", o_res_valid, 0);
        chk("mrst_busy", o_busy, 0);
        chk("mrst_run", o_run, 0);
        step();
        rst_n = 1'b1;
        step();
        run_job(16'h0001, 0, 0, -1, 0, 10'(1));
        take_res(0, 10'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
